// File: rtl/oled_pkg.sv
// oled_pkg: shared FSM state type, SSD1306 init command tables
// and the blank character code for the OLED frame transmitter.
package oled_pkg;

  typedef enum logic [2:0] {
    VDD_ON,
    RES_LO,
    RES_HI,
    INIT1,
    VBAT_ON,
    INIT2,
    FRAME
  } state_t;

  localparam int INIT1_LEN = 5;
  localparam int INIT2_LEN = 7;

  localparam logic [7:0] INIT1_CMDS [INIT1_LEN] = '{
    8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1
  };

  localparam logic [7:0] INIT2_CMDS [INIT2_LEN] = '{
    8'hA1, 8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF
  };

  localparam logic [7:0] BLANK = 8'h20;

endpackage

// File: rtl/oled_font_rom.sv
// oled_font_rom: combinational 5x7 ASCII font, codes 0x20-0x7E.
// code[6:0] ASCII, col[2:0] column; bits = column byte (LSB top), 0 outside glyph.
module oled_font_rom
  import oled_pkg::*;
(
  input  logic [6:0] code,
  input  logic [2:0] col,
  output logic [7:0] bits
);

  // {col0, col1, col2, col3, col4} per glyph, starting at 0x20
  localparam logic [39:0] GLYPH [95] = '{
    40'h0000000000, 40'h00005F0000, 40'h0007000700, 40'h147F147F14,
    40'h242A7F2A12, 40'h2313086462, 40'h3649552250, 40'h0005030000,
    40'h001C224100, 40'h0041221C00, 40'h082A1C2A08, 40'h08083E0808,
    40'h0050300000, 40'h0808080808, 40'h0060600000, 40'h2010080402,
    40'h3E5149453E, 40'h00427F4000, 40'h4261514946, 40'h2141454B31,
    40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
    40'h3649494936, 40'h064949291E, 40'h0036360000, 40'h0056360000,
    40'h0008142241, 40'h1414141414, 40'h4122140800, 40'h0201510906,
    40'h324979413E, 40'h7E1111117E, 40'h7F49494936, 40'h3E41414122,
    40'h7F4141221C, 40'h7F49494941, 40'h7F09090101, 40'h3E41415132,
    40'h7F0808087F, 40'h00417F4100, 40'h2040413F01, 40'h7F08142241,
    40'h7F40404040, 40'h7F0204027F, 40'h7F0408107F, 40'h3E4141413E,
    40'h7F09090906, 40'h3E4151215E, 40'h7F09192946, 40'h4649494931,
    40'h01017F0101, 40'h3F4040403F, 40'h1F2040201F, 40'h7F2018207F,
    40'h6314081463, 40'h0304780403, 40'h6151494543, 40'h00007F4141,
    40'h0204081020, 40'h41417F0000, 40'h0402010204, 40'h4040404040,
    40'h0001020400, 40'h2054545478, 40'h7F48444438, 40'h3844444420,
    40'h384444487F, 40'h3854545418, 40'h087E090102, 40'h081454543C,
    40'h7F08040478, 40'h00447D4000, 40'h2040443D00, 40'h007F102844,
    40'h00417F4000, 40'h7C04180478, 40'h7C08040478, 40'h3844444438,
    40'h7C14141408, 40'h081414187C, 40'h7C08040408, 40'h4854545420,
    40'h043F444020, 40'h3C4040207C, 40'h1C2040201C, 40'h3C4030403C,
    40'h4428102844, 40'h0C5050503C, 40'h4464544C44, 40'h0008364100,
    40'h00007F0000, 40'h0041360800, 40'h08082A1C08
  };

  logic [6:0]  idx;
  logic [39:0] g;

  always_comb begin
    idx = code - BLANK[6:0];
    g   = 40'h0;
    if (code >= BLANK[6:0] && code <= 7'h7E)
      g = GLYPH[idx];
    unique case (col)
      3'd0:    bits = g[39:32];
      3'd1:    bits = g[31:24];
      3'd2:    bits = g[23:16];
      3'd3:    bits = g[15:8];
      3'd4:    bits = g[7:0];
      default: bits = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_frame_tx.sv
// oled_frame_tx: 64-char buffer, SSD1306 power-up/init and endless 128x32 SPI frame stream.
// Ports: clk, rstd (sync, active-low); we/write_addr/write_data buffer writes;
// ready, frame_done status; oled_dc/res/sclk/sdin/vbat/vdd panel pins.
// All outputs are registered; first oled_sclk fall comes 3*DELAY+1 clk
// edges after the first edge that samples rstd=1.
// Macro OLED_CURSOR_EN: inverts the character at the last written address.
module oled_frame_tx
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DELAY   = 100000
) (
  input  logic       clk,
  input  logic       rstd,
  input  logic       we,
  input  logic [5:0] write_addr,
  input  logic [7:0] write_data,
  output logic       ready,
  output logic       frame_done,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_vbat,
  output logic       oled_vdd
);

  state_t      state, state_nx;
  logic [31:0] wcnt, dcnt;
  logic        idle, hi, wrap;
  logic [2:0]  bitn;
  logic [8:0]  bidx;
  logic [7:0]  shreg, byte_nx;
  logic [7:0]  cbuf [64];
  logic [7:0]  ch, rom_bits, fbyte;
  logic        spi, wait_done, byte_end;
  logic        vdd_nx, res_nx, vbat_nx;
  logic        sclk_nx, sdin_nx, dc_nx;
  logic        ready_nx, fd_nx;

`ifdef OLED_CURSOR_EN
  logic [5:0]  cursor;
`endif

  assign spi       = state inside {INIT1, INIT2, FRAME};
  assign wait_done = (wcnt == DELAY - 1);
  assign byte_end  = !idle && hi && (dcnt == CLK_DIV - 1)
                     && (bitn == 3'd7);

  always_ff @(posedge clk) begin
    if (!rstd) state <= VDD_ON;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      VDD_ON:  if (wait_done) state_nx = RES_LO;
      RES_LO:  if (wait_done) state_nx = RES_HI;
      RES_HI:  if (wait_done) state_nx = INIT1;
      INIT1:   if (byte_end && bidx == 9'(INIT1_LEN - 1))
                 state_nx = VBAT_ON;
      VBAT_ON: if (wait_done) state_nx = INIT2;
      INIT2:   if (byte_end && bidx == 9'(INIT2_LEN - 1))
                 state_nx = FRAME;
      FRAME:   state_nx = FRAME;
      default: state_nx = VDD_ON;
    endcase
  end

  always_comb begin
    vdd_nx   = 1'b0;
    res_nx   = (state != RES_LO);
    vbat_nx  = !(state inside {VBAT_ON, INIT2, FRAME});
    sclk_nx  = !spi || idle || hi;
    sdin_nx  = spi && !idle && shreg[7];
    dc_nx    = (state == FRAME);
    ready_nx = (state == FRAME);
    fd_nx    = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      oled_vdd   <= 1'b1;
      oled_vbat  <= 1'b1;
      oled_res   <= 1'b1;
      oled_sclk  <= 1'b1;
      oled_sdin  <= 1'b0;
      oled_dc    <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      oled_vdd   <= vdd_nx;
      oled_vbat  <= vbat_nx;
      oled_res   <= res_nx;
      oled_sclk  <= sclk_nx;
      oled_sdin  <= sdin_nx;
      oled_dc    <= dc_nx;
      ready      <= ready_nx;
      frame_done <= fd_nx;
    end
  end

  // character for frame byte n is buf[n[8:3]], column n[2:0]
  assign ch = cbuf[bidx[8:3]];

  oled_font_rom u_font (
    .code (ch[6:0]),
    .col  (bidx[2:0]),
    .bits (rom_bits)
  );

  always_comb begin
    fbyte = ch[7] ? 8'h00 : rom_bits;
`ifdef OLED_CURSOR_EN
    if (bidx[8:3] == cursor) fbyte = ~fbyte;
`endif
    unique case (state)
      INIT1:   byte_nx = INIT1_CMDS[bidx[2:0]];
      INIT2:   byte_nx = INIT2_CMDS[bidx[2:0]];
      default: byte_nx = fbyte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      wcnt  <= '0;
      dcnt  <= '0;
      idle  <= 1'b1;
      hi    <= 1'b0;
      bitn  <= '0;
      bidx  <= '0;
      shreg <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= (state == FRAME) && byte_end && (bidx == 9'd511);
      wcnt <= (spi || wait_done) ? '0 : wcnt + 32'd1;
      if (!spi) begin
        idle <= 1'b1;
        bidx <= '0;
      end else if (idle) begin
        // fetch cycle: byte captured from the buffer as it is now
        shreg <= byte_nx;
        idle  <= 1'b0;
        hi    <= 1'b0;
        dcnt  <= '0;
        bitn  <= '0;
      end else if (dcnt == CLK_DIV - 1) begin
        dcnt <= '0;
        if (!hi) begin
          hi <= 1'b1;
        end else if (bitn == 3'd7) begin
          idle <= 1'b1;
          bidx <= (state_nx != state) ? '0 : bidx + 9'd1;
        end else begin
          hi    <= 1'b0;
          bitn  <= bitn + 3'd1;
          shreg <= {shreg[6:0], 1'b0};
        end
      end else begin
        dcnt <= dcnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      for (int i = 0; i < 64; i++) cbuf[i] <= BLANK;
    end else if (we) begin
      cbuf[write_addr] <= write_data;
    end
  end

`ifdef OLED_CURSOR_EN
  always_ff @(posedge clk) begin
    if (!rstd)   cursor <= '0;
    else if (we) cursor <= write_addr;
  end
`endif

endmodule

// File: tb/tb_oled_frame_tx.sv
// tb_oled_frame_tx: randomized scoreboard bench for oled_frame_tx.
// Stimulus pushes expected SPI bytes; an SPI monitor pops and compares.
`timescale 1ns/1ps
module tb_oled_frame_tx;

  localparam int CD = 2;
  localparam int DL = 4;

  logic       clk = 1'b0;
  logic       rstd = 1'b0;
  logic       we = 1'b0;
  logic [5:0] write_addr = '0;
  logic [7:0] write_data = '0;
  logic       ready, frame_done, oled_dc, oled_res;
  logic       oled_sclk, oled_sdin, oled_vbat, oled_vdd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_frame_tx #(.CLK_DIV(CD), .DELAY(DL)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .ready      (ready),
    .frame_done (frame_done),
    .oled_dc    (oled_dc),
    .oled_res   (oled_res),
    .oled_sclk  (oled_sclk),
    .oled_sdin  (oled_sdin),
    .oled_vbat  (oled_vbat),
    .oled_vdd   (oled_vdd)
  );

  typedef struct {
    logic [7:0] d;
    logic       dc;
    logic       vbat;
  } exp_t;

  exp_t exp_q[$];

  // reference 5x7 font, {col0..col4} per code from 0x20
  localparam logic [39:0] FT [95] = '{
    40'h0000000000, 40'h00005F0000, 40'h0007000700, 40'h147F147F14,
    40'h242A7F2A12, 40'h2313086462, 40'h3649552250, 40'h0005030000,
    40'h001C224100, 40'h0041221C00, 40'h082A1C2A08, 40'h08083E0808,
    40'h0050300000, 40'h0808080808, 40'h0060600000, 40'h2010080402,
    40'h3E5149453E, 40'h00427F4000, 40'h4261514946, 40'h2141454B31,
    40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
    40'h3649494936, 40'h064949291E, 40'h0036360000, 40'h0056360000,
    40'h0008142241, 40'h1414141414, 40'h4122140800, 40'h0201510906,
    40'h324979413E, 40'h7E1111117E, 40'h7F49494936, 40'h3E41414122,
    40'h7F4141221C, 40'h7F49494941, 40'h7F09090101, 40'h3E41415132,
    40'h7F0808087F, 40'h00417F4100, 40'h2040413F01, 40'h7F08142241,
    40'h7F40404040, 40'h7F0204027F, 40'h7F0408107F, 40'h3E4141413E,
    40'h7F09090906, 40'h3E4151215E, 40'h7F09192946, 40'h4649494931,
    40'h01017F0101, 40'h3F4040403F, 40'h1F2040201F, 40'h7F2018207F,
    40'h6314081463, 40'h0304780403, 40'h6151494543, 40'h00007F4141,
    40'h0204081020, 40'h41417F0000, 40'h0402010204, 40'h4040404040,
    40'h0001020400, 40'h2054545478, 40'h7F48444438, 40'h3844444420,
    40'h384444487F, 40'h3854545418, 40'h087E090102, 40'h081454543C,
    40'h7F08040478, 40'h00447D4000, 40'h2040443D00, 40'h007F102844,
    40'h00417F4000, 40'h7C04180478, 40'h7C08040478, 40'h3844444438,
    40'h7C14141408, 40'h081414187C, 40'h7C08040408, 40'h4854545420,
    40'h043F444020, 40'h3C4040207C, 40'h1C2040201C, 40'h3C4030403C,
    40'h4428102844, 40'h0C5050503C, 40'h4464544C44, 40'h0008364100,
    40'h00007F0000, 40'h0041360800, 40'h08082A1C08
  };

  logic [7:0] init_cmds [12] = '{
    8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
    8'hA1, 8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF
  };

  logic [7:0] mbuf [64];
  int         cur;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] font(input logic [7:0] c, input int k);
    logic [39:0] g;
    if (c < 8'h20 || c > 8'h7E || k > 4) return 8'h00;
    g = FT[int'(c) - 32];
    return g[39 - 8*k -: 8];
  endfunction

  function automatic logic [7:0] model_byte(input int n);
    int page, col, ci;
    logic [7:0] b;
    page = n / 128;
    col  = n % 128;
    ci   = page * 16 + col / 8;
    b    = font(mbuf[ci], col % 8);
`ifdef OLED_CURSOR_EN
    if (ci == cur) b = ~b;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mbuf[i] = 8'h20;
    cur = 0;
  endtask

  task automatic push_init();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.d = init_cmds[i];
      e.dc = 1'b0;
      e.vbat = (i >= 5) ? 1'b0 : 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int n = 0; n < 512; n++) begin
      e.d = model_byte(n);
      e.dc = 1'b1;
      e.vbat = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // SPI monitor / scoreboard checker
  int         cyc = 0;
  int         bits = 0;
  int         nbytes = 0;
  int         start_c = 0;
  int         end_c = -100;
  logic       prev_s = 1'b1;
  logic [7:0] sh = '0;
  exp_t       me;

  always @(negedge clk) begin
    cyc++;
    if (!rstd) begin
      bits = 0;
      prev_s = 1'b1;
      end_c = -100;
    end else begin
      if (prev_s && !oled_sclk && bits == 0) begin
        if (cyc - end_c <= 5)
          chk("byte_period", cyc - start_c, 16 * CD + 1);
        start_c = cyc;
      end
      if (!prev_s && oled_sclk) begin
        sh = {sh[6:0], oled_sdin};
        bits++;
        if (bits == 8) begin
          bits = 0;
          nbytes++;
          end_c = cyc;
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("spi_byte", int'(sh), int'(me.d));
            chk("spi_dc", int'(oled_dc), int'(me.dc));
            chk("spi_vbat", int'(oled_vbat), int'(me.vbat));
          end
        end
      end
      prev_s = oled_sclk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_vdd"}, int'(oled_vdd), 1);
    chk({tag, "_vbat"}, int'(oled_vbat), 1);
    chk({tag, "_res"}, int'(oled_res), 1);
    chk({tag, "_sclk"}, int'(oled_sclk), 1);
    chk({tag, "_sdin"}, int'(oled_sdin), 0);
    chk({tag, "_dc"}, int'(oled_dc), 0);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // called right after rstd is released
  task automatic power_seq();
    int n, low;
    @(posedge clk);
    @(negedge clk);
    chk("vdd_on", int'(oled_vdd), 0);
    chk("res_idle_hi", int'(oled_res), 1);
    n = 0;
    while (oled_res && n < 100) begin @(negedge clk); n++; end
    chk("res_fall_delay", n, DL);
    chk("vdd_before_res", int'(oled_vdd), 0);
    low = 0;
    while (!oled_res && low < 100) begin @(negedge clk); n++; low++; end
    chk("res_low_len", low, DL);
    while (oled_sclk && n < 300) begin @(negedge clk); n++; end
    chk("first_sclk_fall", n, 3 * DL + 1);
    chk("vbat_off_init1", int'(oled_vbat), 1);
    chk("ready_low_init", int'(ready), 0);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 20000) begin @(negedge clk); n++; end
    chk("frame_done_seen", int'(frame_done), 1);
    chk("ready_in_frame", int'(ready), 1);
    @(negedge clk);
    chk("frame_done_pulse", int'(frame_done), 0);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin @(negedge clk); n++; end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    tick();
    we = 1'b1;
    write_addr = a;
    write_data = d;
    mbuf[a] = d;
    cur = int'(a);
  endtask

  initial begin
    int n;
    model_reset();
    rstd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals("rst");

    push_init();
    tick();
    rstd = 1'b1;
    power_seq();

    // abort mid INIT2 byte (C8) during bit 3
    n = 0;
    while (!(nbytes == 6 && bits == 3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_init2_bit3", int'(nbytes == 6 && bits == 3), 1);
    tick();
    tick();
    rstd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_vals("midrst");
    exp_q.delete();
    model_reset();
    push_init();
    push_frame();
    tick();
    rstd = 1'b1;
    power_seq();
    wait_drain("drain_init_blank");

    wait_fd();
    for (int i = 0; i < 24; i++)
      wr(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    wr(6'd0, 8'h2B);
    wr(6'b10_0011, 8'h2D);
    wr(6'd5, 8'h2C);
    tick();
    we = 1'b0;

    wait_fd();
    push_frame();
    wait_drain("drain_glyph_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
